// File: rtl/requant_pkg.sv
// Shared widths, vector types and per-channel config for the requantization stage.
package requant_pkg;

   localparam int unsigned OC_PAR      = 16;
   localparam int unsigned ACC_WIDTH   = 28;
   localparam int unsigned BIAS_WIDTH  = 32;
   localparam int unsigned SCALE_WIDTH = 16;
   localparam int unsigned OUT_WIDTH   = 8;
   localparam int unsigned SHIFT_WIDTH = 5;
   localparam int unsigned CH_WIDTH    = $clog2(OC_PAR);
   localparam int unsigned CNT_WIDTH   = 32;

   // Bias add widens by one bit; the product adds the zero-extended scale.
   localparam int unsigned SUM_WIDTH  = ((BIAS_WIDTH > ACC_WIDTH) ? BIAS_WIDTH : ACC_WIDTH) + 1;
   localparam int unsigned PROD_WIDTH = SUM_WIDTH + SCALE_WIDTH + 1;

   localparam int INT8_MAX = 127;
   localparam int INT8_MIN = -128;

   typedef logic [OC_PAR-1:0][ACC_WIDTH-1:0] acc_vec_t;
   typedef logic [OC_PAR-1:0][OUT_WIDTH-1:0] pix_vec_t;

   typedef struct packed {
      logic signed [BIAS_WIDTH-1:0] bias;
      logic [SCALE_WIDTH-1:0]       scale;
   } chan_cfg_t;

endpackage

// File: rtl/requant_lane.sv
// One output channel: bias add, scale multiply, rounding shift, ReLU and int8 saturation.
// With REQUANT_SAT_STATS_EN defined, exposes a per-lane clip flag for the S3 result.
module requant_lane
   import requant_pkg::*;
(
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         adv,
   input  logic signed [ACC_WIDTH-1:0]  acc,
   input  logic signed [BIAS_WIDTH-1:0] bias,
   input  logic [SCALE_WIDTH-1:0]       scale,
   input  logic [SHIFT_WIDTH-1:0]       shift,
   input  logic                         relu,
`ifdef REQUANT_SAT_STATS_EN
   output logic                         clip_c,
`endif
   output logic signed [OUT_WIDTH-1:0]  pix
);

   logic signed [SUM_WIDTH-1:0]  sum_q;
   logic signed [PROD_WIDTH-1:0] prod_q;
   logic signed [PROD_WIDTH-1:0] rnd_c;
   logic signed [PROD_WIDTH-1:0] shr_c;
   logic signed [OUT_WIDTH-1:0]  sat_c;
   logic                         hi_c;
   logic                         lo_c;

   // S3: round half toward +inf, shift, clamp negatives under ReLU, saturate.
   always_comb begin
      rnd_c = prod_q;
      if (shift != '0)
         rnd_c = prod_q + (PROD_WIDTH'(1) << (shift - SHIFT_WIDTH'(1)));
      shr_c = rnd_c >>> shift;
      if (relu && shr_c[PROD_WIDTH-1])
         shr_c = '0;
      hi_c  = shr_c > PROD_WIDTH'(INT8_MAX);
      lo_c  = shr_c < PROD_WIDTH'(INT8_MIN);
      sat_c = shr_c[OUT_WIDTH-1:0];
      if (hi_c)
         sat_c = OUT_WIDTH'(INT8_MAX);
      else if (lo_c)
         sat_c = OUT_WIDTH'(INT8_MIN);
   end

`ifdef REQUANT_SAT_STATS_EN
   assign clip_c = hi_c || lo_c;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q  <= '0;
         prod_q <= '0;
         pix    <= '0;
      end else if (adv) begin
         sum_q  <= SUM_WIDTH'(acc) + SUM_WIDTH'(bias);
         prod_q <= PROD_WIDTH'(sum_q) * PROD_WIDTH'(signed'({1'b0, scale}));
         pix    <= sat_c;
      end
   end

endmodule

// File: rtl/requant_stage.sv
// 3-stage requantization of a 16-lane accumulator vector to int8 with valid/ready flow control.
// Optional REQUANT_SAT_STATS_EN adds a saturating count of clipped lanes (sat_count).
module requant_stage
   import requant_pkg::*;
(
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [OC_PAR*ACC_WIDTH-1:0]   acc_in,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [OC_PAR*OUT_WIDTH-1:0]   pix_out,
   input  logic                          cfg_we,
   input  logic [CH_WIDTH-1:0]           cfg_ch,
   input  logic signed [BIAS_WIDTH-1:0]  cfg_bias,
   input  logic [SCALE_WIDTH-1:0]        cfg_scale,
   input  logic [SHIFT_WIDTH-1:0]        cfg_shift,
   input  logic                          cfg_relu,
`ifdef REQUANT_SAT_STATS_EN
   output logic [CNT_WIDTH-1:0]          sat_count,
`endif
   output logic                          busy
);

   logic                   adv_c;
   logic                   v1_q;
   logic                   v2_q;
   chan_cfg_t              cfg_q [OC_PAR];
   logic [SHIFT_WIDTH-1:0] shift_q;
   logic                   relu_q;
   acc_vec_t               acc_v;
   pix_vec_t               pix_v;

   // The whole pipeline moves together; only a stalled output blocks it.
   assign adv_c    = !out_valid || out_ready;
   assign in_ready = adv_c;
   assign busy     = v1_q || v2_q || out_valid;
   assign acc_v    = acc_in;
   assign pix_out  = pix_v;

   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q      <= 1'b0;
         v2_q      <= 1'b0;
         out_valid <= 1'b0;
      end else if (adv_c) begin
         v1_q      <= in_valid;
         v2_q      <= v1_q;
         out_valid <= v2_q;
      end
   end

   // Reset config is identity: bias 0, scale 1, no shift, no ReLU.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < OC_PAR; k++)
            cfg_q[k] <= '{bias: '0, scale: SCALE_WIDTH'(1)};
         shift_q <= '0;
         relu_q  <= 1'b0;
      end else if (cfg_we) begin
         shift_q <= cfg_shift;
         relu_q  <= cfg_relu;
         if (32'(cfg_ch) < OC_PAR)
            cfg_q[cfg_ch] <= '{bias: cfg_bias, scale: cfg_scale};
      end
   end

`ifdef REQUANT_SAT_STATS_EN
   logic [OC_PAR-1:0]     clip_c;
   logic [CH_WIDTH:0]     nclip_c;
   logic [CNT_WIDTH:0]    cnt_sum_c;

   always_comb begin
      nclip_c = '0;
      for (int k = 0; k < OC_PAR; k++)
         nclip_c = nclip_c + (CH_WIDTH+1)'(clip_c[k]);
      cnt_sum_c = (CNT_WIDTH+1)'(sat_count) + (CNT_WIDTH+1)'(nclip_c);
   end

   // Counts clipped lanes of each valid vector leaving S3; sticks at all-ones.
   always_ff @(posedge clk) begin
      if (rst)
         sat_count <= '0;
      else if (adv_c && v2_q)
         sat_count <= cnt_sum_c[CNT_WIDTH] ? '1 : cnt_sum_c[CNT_WIDTH-1:0];
   end
`endif

   for (genvar k = 0; k < OC_PAR; k++) begin : g_lane
      requant_lane u_lane (
         .clk    (clk),
         .rst    (rst),
         .adv    (adv_c),
         .acc    (acc_v[k]),
         .bias   (cfg_q[k].bias),
         .scale  (cfg_q[k].scale),
         .shift  (shift_q),
         .relu   (relu_q),
`ifdef REQUANT_SAT_STATS_EN
         .clip_c (clip_c[k]),
`endif
         .pix    (pix_v[k])
      );
   end

`ifndef SYNTHESIS
   // Config may only change while the pipeline is empty.
   a_cfg_idle: assert property (@(posedge clk) disable iff (rst) !(cfg_we && busy))
      else $error("requant_stage: cfg_we asserted while busy");
`endif

endmodule

// File: doc/requant_stage.md
Name: requant_stage

Overview:
- Downstream of the processing element; consumes its 16-lane signed 28-bit accumulator vector.
- Per output channel: bias add, fixed-point scale multiply, rounding right shift, optional ReLU, saturation to signed 8-bit.
- Result feeds the activation write-back buffer.
- 3-stage pipeline with a valid/ready handshake; in_ready lets the tile controller stall the PE `en`.

Parameters:
- OC_PAR, 16, number of output-channel lanes
- ACC_WIDTH, 28, signed accumulator width per lane
- BIAS_WIDTH, 32, signed bias width
- SCALE_WIDTH, 16, unsigned scale multiplier width
- OUT_WIDTH, 8, signed output width
- SHIFT_WIDTH, 5, width of the right-shift amount

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  acc_in holds a valid accumulator vector
- in_ready  out  1  stage accepts acc_in this cycle
- acc_in  in  OC_PAR*ACC_WIDTH  signed accumulators, lane k at [k]
- out_valid  out  1  pix_out valid
- out_ready  in  1  consumer accepts pix_out
- pix_out  out  OC_PAR*OUT_WIDTH  signed int8 results, lane k at [k]
- cfg_we  in  1  write per-channel config
- cfg_ch  in  $clog2(OC_PAR)  lane index for the write
- cfg_bias  in  BIAS_WIDTH  signed bias for lane cfg_ch
- cfg_scale  in  SCALE_WIDTH  unsigned scale for lane cfg_ch
- cfg_shift  in  SHIFT_WIDTH  global shift; written on every cfg_we
- cfg_relu  in  1  global ReLU enable; written on every cfg_we
- busy  out  1  OR of all stage valid bits

Behaviour:
- Reset (clk edge with rst=1):
  - all stage valids 0, out_valid 0, pix_out 0, busy 0.
  - bias 0, scale 1, shift 0, relu 0 for all lanes; this config is identity with saturation.
- Global advance: adv = !out_valid || out_ready. in_ready = adv (combinational). When adv=0 all stage registers and valids hold.
- Accept when in_valid && in_ready. Latency is exactly 3 cycles from accept to out_valid when out_ready is held at 1. Throughput is 1 vector per cycle.
- S1: sum = sext(acc) + bias, 33-bit signed.
- S2: prod = sum * zext(scale), 50-bit signed.
- S3, in this order:
  - if shift>0, add 1<<(shift-1) (round half toward +inf);
  - arithmetic right shift by shift;
  - if relu and negative, force 0;
  - saturate to [-128, 127];
  - register into pix_out.
- pix_out and out_valid are stable while out_valid && !out_ready.
- Config:
  - a cfg_we write takes effect in the cycle after the write edge;
  - the controller writes only while busy=0;
  - a write while busy=1 is a protocol violation; a `ifndef SYNTHESIS assertion flags it.
- Empty pipeline with out_ready=0: in_ready=1, so bubbles fill the pipeline until out_valid is asserted.
- Simultaneous accept and output handshake in one cycle: both occur and the pipeline shifts.
- rst mid-stream: in-flight data is discarded and config returns to reset values.
- cfg_ch outside OC_PAR range (non-power-of-2 OC_PAR): the write is ignored.

Optional Feature:
- Macro: REQUANT_SAT_STATS_EN.
- With the macro defined:
  - adds output sat_count, 32 bits;
  - sat_count increments by the number of lanes clipped at S3 for each vector leaving S3 on adv;
  - it saturates at 2^32-1 and clears on rst.
- Without the macro: no port and no counter logic.

Decomposition:
- Package requant_pkg holds:
  - the width localparams;
  - typedef acc_vec_t (packed [OC_PAR][ACC_WIDTH]);
  - typedef pix_vec_t;
  - typedef chan_cfg_t struct {bias, scale};
  - the constants INT8_MAX and INT8_MIN.
- Sub-module requant_lane: one lane's S1–S3 datapath (arithmetic only); it takes adv and its cfg slice and is instantiated OC_PAR times.
- Top level owns the valids, handshake, config registers and stats.

Test Plan:
- Reset defaults, acc lane0=100, lane1=-300, lane2=50 -> 3 cycles later pix_out lane0=100, lane1=-128, lane2=50; out_valid=1.
- Lane0 bias=0, scale=3, shift=2, acc=100 -> 75. Lane1 scale=1, shift=1, acc=-7 -> -3 (rounding).
- relu=1, bias=-50, acc=20 -> 0. Same config, acc=1000 -> 127. With the macro defined, sat_count +1 for the clipped lane.
- Stream 8 vectors with out_ready toggling 1,0,0,1,...:
  - all 8 delivered in order, none lost or duplicated;
  - in_ready=0 exactly when out_valid && !out_ready;
  - pix_out held stable during stall.
- Continuous in_valid with out_ready=1 -> one output per cycle after a 3-cycle fill; busy falls 3 cycles after the last accept.
- Assert rst with 3 vectors in flight -> next cycle out_valid=0, busy=0, config back to defaults; the next vector obeys identity behaviour.
